// File: rtl/vga_text_console_ctrl.sv
// Text console controller: arbitrates two character sources, writes printable
// glyphs into a character buffer, tracks the cursor and scrolls the screen.
module vga_text_console_ctrl #(
   parameter int COLS = 70,
   parameter int ROWS = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [7:0]  req0_char,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [7:0]  req1_char,
   output logic        req1_ready,
   output logic [11:0] mem_addr,
   output logic        mem_we,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic [6:0]  cursor_x,
   output logic [4:0]  cursor_y,
   output logic        busy
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] WRITE     = 3'd1;
   localparam logic [2:0] SCROLL_RD = 3'd2;
   localparam logic [2:0] SCROLL_WR = 3'd3;
   localparam logic [2:0] CLEAR     = 3'd4;

   localparam logic [6:0] LAST_COL = 7'(COLS - 1);
   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

   logic [2:0] state;
   logic [6:0] cur_x;
   logic [4:0] cur_y;
   logic [6:0] scr_col;
   logic [4:0] scr_row;
   logic [7:0] wr_data;
   logic       wr_advance;
   logic       last_grant;
   logic       grant0;
   logic       grant1;
   logic       accept;
   logic [7:0] in_char;
   logic       printable;

   // last_grant names the requester served most recently; the other one wins a tie.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE) begin
         if (req0_valid && (!req1_valid || last_grant))
            grant0 = 1'b1;
         else if (req1_valid)
            grant1 = 1'b1;
      end
   end

   assign accept     = grant0 | grant1;
   assign in_char    = grant0 ? req0_char : req1_char;
   assign printable  = (in_char >= 8'h20) && (in_char <= 8'h7E);
   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign cursor_x   = cur_x;
   assign cursor_y   = cur_y;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cur_x      <= '0;
         cur_y      <= '0;
         scr_col    <= '0;
         scr_row    <= '0;
         wr_data    <= '0;
         wr_advance <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  last_grant <= grant1;
                  if (printable) begin
                     wr_data    <= in_char;
                     wr_advance <= 1'b1;
                     state      <= WRITE;
                  end else if (in_char == 8'h0A) begin
                     cur_x <= '0;
                     if (cur_y < LAST_ROW) begin
                        cur_y <= cur_y + 5'd1;
                     end else begin
                        scr_row <= 5'd1;
                        scr_col <= '0;
                        state   <= SCROLL_RD;
                     end
                  end else if (in_char == 8'h0D) begin
                     cur_x <= '0;
                  end else if (in_char == 8'h08) begin
                     // Backspace moves first, then blanks the cell it landed on.
                     if (cur_x != 7'd0) begin
                        cur_x      <= cur_x - 7'd1;
                        wr_data    <= 8'h20;
                        wr_advance <= 1'b0;
                        state      <= WRITE;
                     end else if (cur_y != 5'd0) begin
                        cur_x      <= LAST_COL;
                        cur_y      <= cur_y - 5'd1;
                        wr_data    <= 8'h20;
                        wr_advance <= 1'b0;
                        state      <= WRITE;
                     end
                  end
               end
            end
            WRITE: begin
               if (!wr_advance) begin
                  state <= IDLE;
               end else if (cur_x == LAST_COL) begin
                  cur_x <= '0;
                  if (cur_y < LAST_ROW) begin
                     cur_y <= cur_y + 5'd1;
                     state <= IDLE;
                  end else begin
                     scr_row <= 5'd1;
                     scr_col <= '0;
                     state   <= SCROLL_RD;
                  end
               end else begin
                  cur_x <= cur_x + 7'd1;
                  state <= IDLE;
               end
            end
            SCROLL_RD: begin
               state <= SCROLL_WR;
            end
            SCROLL_WR: begin
               if (scr_col == LAST_COL) begin
                  scr_col <= '0;
                  if (scr_row == LAST_ROW) begin
                     state <= CLEAR;
                  end else begin
                     scr_row <= scr_row + 5'd1;
                     state   <= SCROLL_RD;
                  end
               end else begin
                  scr_col <= scr_col + 7'd1;
                  state   <= SCROLL_RD;
               end
            end
            CLEAR: begin
               if (scr_col == LAST_COL) begin
                  scr_col <= '0;
                  state   <= IDLE;
               end else begin
                  scr_col <= scr_col + 7'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The buffer read issued in SCROLL_RD returns its data during SCROLL_WR.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         WRITE: begin
            mem_we    = 1'b1;
            mem_addr  = {cur_y, cur_x};
            mem_wdata = wr_data;
         end
         SCROLL_RD: begin
            mem_addr  = {scr_row, scr_col};
         end
         SCROLL_WR: begin
            mem_we    = 1'b1;
            mem_addr  = {scr_row - 5'd1, scr_col};
            mem_wdata = mem_rdata;
         end
         CLEAR: begin
            mem_we    = 1'b1;
            mem_addr  = {LAST_ROW, scr_col};
            mem_wdata = 8'h20;
         end
         default: begin
            mem_we    = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_vga_text_console_ctrl.sv
// Bench for vga_text_console_ctrl: directed scenarios followed by random traffic,
// checked against a screen-level model of the console.
module tb_vga_text_console_ctrl;

   localparam int COLS = 70;
   localparam int ROWS = 30;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0;
   logic [7:0]  req0_char = 8'h00;
   logic        req0_ready;
   logic        req1_valid = 1'b0;
   logic [7:0]  req1_char = 8'h00;
   logic        req1_ready;
   logic [11:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = 8'h00;
   logic [6:0]  cursor_x;
   logic [4:0]  cursor_y;
   logic        busy;

   vga_text_console_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_char  (req0_char),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_char  (req1_char),
      .req1_ready (req1_ready),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .cursor_x   (cursor_x),
      .cursor_y   (cursor_y),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Character buffer with one-cycle registered read.
   byte unsigned char_mem [4096];
   always @(posedge clk) begin
      if (mem_we) char_mem[mem_addr] <= mem_wdata;
      mem_rdata <= char_mem[mem_addr];
   end

   // Protocol monitor sampled on the falling edge.
   int          idle_viol = 0;
   int          ready_viol = 0;
   int          write_count = 0;
   logic [11:0] last_addr = '0;
   logic [7:0]  last_data = '0;
   always @(negedge clk) begin
      if (!reset) begin
         if (!busy && (mem_we || mem_addr != 12'd0)) idle_viol <= idle_viol + 1;
         if (busy && (req0_ready || req1_ready)) ready_viol <= ready_viol + 1;
         if (mem_we) begin
            write_count <= write_count + 1;
            last_addr   <= mem_addr;
            last_data   <= mem_wdata;
         end
      end
   end

   // Screen-level reference model.
   byte unsigned screen [ROWS][COLS];
   int mx = 0;
   int my = 0;

   int total_checks = 0;
   int passed_checks = 0;
   int failed_checks = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total_checks++;
      assert (observed === expected) passed_checks++;
      else begin
         failed_checks++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic modelNewline();
      if (my < ROWS - 1) begin
         my++;
      end else begin
         for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++)
               screen[r][c] = screen[r + 1][c];
         for (int c = 0; c < COLS; c++) screen[ROWS - 1][c] = 8'h20;
      end
   endtask

   task automatic modelApply(input logic [7:0] ch);
      if (ch >= 8'h20 && ch <= 8'h7E) begin
         screen[my][mx] = ch;
         if (mx == COLS - 1) begin
            mx = 0;
            modelNewline();
         end else begin
            mx++;
         end
      end else if (ch == 8'h0A) begin
         mx = 0;
         modelNewline();
      end else if (ch == 8'h0D) begin
         mx = 0;
      end else if (ch == 8'h08) begin
         if (mx > 0 || my > 0) begin
            if (mx > 0) begin
               mx--;
            end else begin
               mx = COLS - 1;
               my--;
            end
            screen[my][mx] = 8'h20;
         end
      end
   endtask

   task automatic checkCursor(input string tag);
      checkOutput({tag, "_x"}, 32'(cursor_x), 32'(mx));
      checkOutput({tag, "_y"}, 32'(cursor_y), 32'(my));
   endtask

   task automatic compareScreen(input string tag);
      int mism;
      mism = 0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (char_mem[r * 128 + c] != screen[r][c]) mism++;
      checkOutput(tag, 32'(mism), 32'd0);
   endtask

   task automatic doReset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      mx = 0;
      my = 0;
   endtask

   // Offers one character on a port, waits for the grant and for the controller
   // to return to idle, then mirrors the character into the model.
   task automatic applyStimulus(input int port, input logic [7:0] ch, output int busy_cycles);
      int waited;
      @(negedge clk);
      if (port == 0) begin
         req0_valid = 1'b1;
         req0_char  = ch;
      end else begin
         req1_valid = 1'b1;
         req1_char  = ch;
      end
      #1;
      waited = 0;
      while (!(port == 0 ? req0_ready : req1_ready) && waited < 10000) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (waited >= 10000) checkOutput("grant_timeout", 32'(waited), 32'd0);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      busy_cycles = 0;
      @(negedge clk);
      while (busy && busy_cycles < 10000) begin
         busy_cycles++;
         @(negedge clk);
      end
      if (busy_cycles >= 10000) checkOutput("idle_timeout", 32'(busy_cycles), 32'd0);
      modelApply(ch);
   endtask

   initial begin
      #1500000;
      $display("[TB] FAIL watchdog simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int bc;
      int wc_before;
      int r;
      int port;
      logic [7:0] ch;

      for (int rr = 0; rr < ROWS; rr++)
         for (int c = 0; c < COLS; c++) screen[rr][c] = 8'h00;

      // Reset state
      doReset();
      #1;
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_we", 32'(mem_we), 32'd0);
      checkOutput("rst_addr", 32'(mem_addr), 32'd0);
      checkOutput("rst_wdata", 32'(mem_wdata), 32'd0);
      checkOutput("rst_rdy0", 32'(req0_ready), 32'd0);
      checkOutput("rst_rdy1", 32'(req1_ready), 32'd0);
      checkCursor("rst_cur");

      // Single character from the keyboard
      @(negedge clk);
      req0_valid = 1'b1;
      req0_char  = 8'h41;
      #1;
      checkOutput("a_rdy0", 32'(req0_ready), 32'd1);
      checkOutput("a_rdy1", 32'(req1_ready), 32'd0);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      @(negedge clk);
      checkOutput("a_we", 32'(mem_we), 32'd1);
      checkOutput("a_addr", 32'(mem_addr), 32'h000);
      checkOutput("a_wdata", 32'(mem_wdata), 32'h41);
      checkOutput("a_busy", 32'(busy), 32'd1);
      @(negedge clk);
      modelApply(8'h41);
      checkOutput("a_idle", 32'(busy), 32'd0);
      checkCursor("a_cur");

      // Simultaneous requests: round-robin
      doReset();
      @(negedge clk);
      req0_valid = 1'b1;
      req0_char  = "x";
      req1_valid = 1'b1;
      req1_char  = "y";
      #1;
      checkOutput("rr_first_rdy0", 32'(req0_ready), 32'd1);
      checkOutput("rr_first_rdy1", 32'(req1_ready), 32'd0);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      @(negedge clk);
      checkOutput("rr_write_rdy1", 32'(req1_ready), 32'd0);
      checkOutput("rr_x_addr", 32'(mem_addr), 32'h000);
      checkOutput("rr_x_data", 32'(mem_wdata), 32'(8'h78));
      @(negedge clk);
      checkOutput("rr_second_rdy1", 32'(req1_ready), 32'd1);
      @(posedge clk);
      #1;
      req1_valid = 1'b0;
      @(negedge clk);
      checkOutput("rr_y_addr", 32'(mem_addr), 32'h001);
      checkOutput("rr_y_data", 32'(mem_wdata), 32'(8'h79));
      @(negedge clk);
      modelApply("x");
      modelApply("y");
      checkCursor("rr_cur");
      req0_valid = 1'b1;
      req0_char  = 8'h00;
      req1_valid = 1'b1;
      req1_char  = 8'h00;
      #1;
      checkOutput("rr_back_rdy0", 32'(req0_ready), 32'd1);
      checkOutput("rr_back_rdy1", 32'(req1_ready), 32'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // Wrap at the end of a row without scrolling
      doReset();
      repeat (5) applyStimulus(0, 8'h0A, bc);
      for (int i = 0; i < COLS - 1; i++) applyStimulus(i % 2, 8'(8'h61 + i % 26), bc);
      checkCursor("wrap_pre");
      applyStimulus(1, "Z", bc);
      checkOutput("wrap_addr", 32'(last_addr), 32'({5'd5, 7'd69}));
      checkOutput("wrap_data", 32'(last_data), 32'(8'h5A));
      checkOutput("wrap_noscroll", 32'(bc), 32'd1);
      checkCursor("wrap_cur");

      // Backspace across a row boundary and at the origin
      doReset();
      repeat (3) applyStimulus(0, 8'h0A, bc);
      applyStimulus(0, 8'h08, bc);
      checkOutput("bs_addr", 32'(last_addr), 32'({5'd2, 7'd69}));
      checkOutput("bs_data", 32'(last_data), 32'h20);
      checkCursor("bs_cur");
      doReset();
      wc_before = write_count;
      applyStimulus(1, 8'h08, bc);
      checkOutput("bs0_nowrite", 32'(write_count), 32'(wc_before));
      checkOutput("bs0_busy", 32'(bc), 32'd0);
      checkCursor("bs0_cur");

      // Full scroll from the last row
      doReset();
      repeat (ROWS - 1) applyStimulus(0, 8'h0A, bc);
      for (int i = 0; i < 10; i++) applyStimulus(1, 8'(8'h30 + i), bc);
      for (int c = 0; c < COLS; c++) applyStimulus(0, 8'h0D, bc);
      for (int i = 0; i < 10; i++) applyStimulus(0, " ", bc);
      checkCursor("scr_pre");
      @(negedge clk);
      req0_valid = 1'b1;
      req0_char  = 8'h0A;
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b1;
      req1_char  = 8'h00;
      bc = 0;
      @(negedge clk);
      while (busy && bc < 10000) begin
         bc++;
         @(negedge clk);
      end
      modelApply(8'h0A);
      checkOutput("scr_cycles", 32'(bc), 32'd4130);
      checkOutput("scr_rdy1_after", 32'(req1_ready), 32'd1);
      @(posedge clk);
      #1;
      req1_valid = 1'b0;
      modelApply(8'h00);
      @(negedge clk);
      checkCursor("scr_cur");
      checkOutput("scr_ready_low", 32'(ready_viol), 32'd0);
      compareScreen("scr_screen");

      // Random traffic
      doReset();
      for (int i = 0; i < 250; i++) begin
         r    = $urandom_range(0, 99);
         port = $urandom_range(0, 1);
         if (r < 75)      ch = 8'($urandom_range(32, 126));
         else if (r < 78) ch = 8'h0A;
         else if (r < 83) ch = 8'h0D;
         else if (r < 93) ch = 8'h08;
         else if (r < 96) ch = 8'($urandom_range(0, 7));
         else             ch = 8'($urandom_range(127, 255));
         applyStimulus(port, ch, bc);
         checkCursor("rnd_cur");
      end
      compareScreen("rnd_screen");
      checkOutput("idle_bus_quiet", 32'(idle_viol), 32'd0);
      checkOutput("busy_ready_low", 32'(ready_viol), 32'd0);

      // Reset in the middle of a scroll
      doReset();
      repeat (ROWS - 1) applyStimulus(0, 8'h0A, bc);
      @(negedge clk);
      req0_valid = 1'b1;
      req0_char  = 8'h0A;
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      checkOutput("abort_pre_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_we", 32'(mem_we), 32'd0);
      checkOutput("abort_addr", 32'(mem_addr), 32'd0);
      checkOutput("abort_x", 32'(cursor_x), 32'd0);
      checkOutput("abort_y", 32'(cursor_y), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("abort_stays_idle", 32'(busy), 32'd0);
      checkOutput("abort_no_clear", 32'(mem_we), 32'd0);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
